page_sequencer: RTL and testbench

Single-clock controller that sequences the paged dual-port event buffer. It accepts an event stream (valid/ready with end-of-event marker) and writes each event into its own page, recording the per-page entry count. Completed pages are drained in order through a 2-cycle-latency read port into a valid/ready output stream, and each page is recycled after its last entry is delivered. It sits between the hit formatter and the readout link, and owns all write/read/page control of the buffer.

---
 rtl/page_seq_pkg.sv | 23 ++
 rtl/page_out_fifo.sv | 65 ++++++
 rtl/page_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_page_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/page_seq_pkg.sv
// Shared constants, FSM state encodings and helpers for the paged event buffer sequencer.
package page_seq_pkg;

    localparam int NENT_W = 5;
    localparam logic [NENT_W-1:0] MAX_ENT = 5'd31;
    localparam int SKID_DEPTH = 3;

    // Write FSM states
    localparam logic [0:0] W_WAIT = 1'b0;
    localparam logic [0:0] W_FILL = 1'b1;

    // Read FSM states
    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_ISSUE = 2'd1;
    localparam logic [1:0] R_FLUSH = 2'd2;

    // Entry count recorded for a page when its last beat arrives with write index wcnt.
    // Once the page is full, further beats are dropped, so the count saturates at MAX_ENT.
    function automatic logic [NENT_W-1:0] final_count(input logic [NENT_W-1:0] wcnt);
        return (wcnt < MAX_ENT) ? wcnt + 5'd1 : MAX_ENT;
    endfunction

endpackage

// File: rtl/page_out_fifo.sv
// Small skid FIFO between the read-data pipeline and the output stream.
// It is fall-through: with nothing stored, an incoming word is presented on the
// output in the same cycle, so a free-flowing drain adds no extra latency.
module page_out_fifo
    import page_seq_pkg::*;
#(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic [WIDTH-1:0] mem [SKID_DEPTH];
    logic [1:0] head;
    logic [1:0] tail;
    logic [1:0] count;
    logic       empty;
    logic       fire;
    logic       store;
    logic       deq;

    function automatic logic [1:0] bump(input logic [1:0] p);
        return (p == 2'(SKID_DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    // A word consumed straight through the bypass path never needs to be stored.
    always_comb begin
        empty     = (count == 2'd0);
        out_valid = !empty || push;
        out_data  = empty ? push_data : mem[head];
        fire      = out_valid && pop;
        store     = push && !(empty && fire);
        deq       = fire && !empty;
        occupancy = count;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= 2'd0;
            tail  <= 2'd0;
            count <= 2'd0;
        end else begin
            if (store) tail <= bump(tail);
            if (deq) head <= bump(head);
            case ({store, deq})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (store) mem[tail] <= push_data;
    end

endmodule

// File: rtl/page_sequencer.sv
// Page sequencer: writes each incoming event into its own buffer page and drains
// committed pages in order through the 2-cycle read port into the output stream.
module page_sequencer
    import page_seq_pkg::*;
#(
    parameter int RAM_WIDTH = 18,
    parameter int PAGES     = 4,
    parameter int PAGE_W    = 2,
    parameter int ADDR_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [RAM_WIDTH-1:0] in_data,
    input  logic                 in_last,
    output logic                 mem_wea,
    output logic [PAGE_W-1:0]    mem_pagea,
    output logic [ADDR_W-1:0]    mem_addra,
    output logic [RAM_WIDTH-1:0] mem_dina,
    output logic                 mem_enb,
    output logic [PAGE_W-1:0]    mem_pageb,
    output logic [ADDR_W-1:0]    mem_addrb,
    output logic                 mem_regceb,
    output logic                 mem_rstb,
    input  logic [RAM_WIDTH-1:0] mem_doutb,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [RAM_WIDTH-1:0] out_data,
    output logic                 out_last,
    output logic [NENT_W-1:0]    out_nent,
    output logic                 ovf_err,
    output logic [PAGE_W:0]      pages_used
);

    localparam logic [PAGE_W:0] PAGES_V = (PAGE_W + 1)'(PAGES);

    logic [0:0]        w_state;
    logic [1:0]        r_state;
    logic [PAGE_W-1:0] wr_page;
    logic [PAGE_W-1:0] rd_page;
    logic [NENT_W-1:0] wcnt;
    logic [NENT_W-1:0] raddr;
    logic [NENT_W-1:0] cnt [PAGES];
    logic [PAGE_W:0]   ready_cnt;
    logic [PAGE_W:0]   pages_next;
    logic [PAGE_W:0]   ready_next;

    logic v1, v2, l1, l2;
    logic accept, commit, free, last_addr, credit_ok;
    logic [1:0] occ;
    logic [2:0] inflight;
    logic [RAM_WIDTH:0] fifo_out;

    // Handshakes, memory port drive and read credit.
    always_comb begin
        in_ready   = (w_state == W_FILL);
        accept     = in_valid && in_ready;
        commit     = accept && in_last;
        mem_wea    = accept && (wcnt < MAX_ENT);
        mem_pagea  = wr_page;
        mem_addra  = ADDR_W'(wcnt);
        mem_dina   = in_data;
        free       = (r_state == R_FLUSH) && out_valid && out_ready && out_last;
        inflight   = {1'b0, occ} + {2'b00, v1} + {2'b00, v2};
        credit_ok  = inflight < 3'(SKID_DEPTH);
        last_addr  = (raddr == cnt[rd_page] - 5'd1);
        mem_enb    = (r_state == R_ISSUE) && credit_ok;
        mem_pageb  = rd_page;
        mem_addrb  = ADDR_W'(raddr);
        mem_regceb = 1'b1;
        mem_rstb   = 1'b0;
        out_nent   = cnt[rd_page];
        out_data   = fifo_out[RAM_WIDTH:1];
        out_last   = fifo_out[0];
    end

    // A commit and a free in the same cycle cancel out in both page counters.
    always_comb begin
        pages_next = pages_used;
        ready_next = ready_cnt;
        if (commit && !free) begin
            pages_next = pages_used + 1'b1;
            ready_next = ready_cnt + 1'b1;
        end else if (!commit && free) begin
            pages_next = pages_used - 1'b1;
            ready_next = ready_cnt - 1'b1;
        end
    end

    // Write side: fill the current page, commit it on the last beat, stall when all pages are busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state <= W_WAIT;
            wr_page <= '0;
            wcnt    <= '0;
            ovf_err <= 1'b0;
            for (int p = 0; p < PAGES; p++) cnt[p] <= '0;
        end else begin
            case (w_state)
                W_WAIT: begin
                    if (pages_used < PAGES_V) w_state <= W_FILL;
                end
                W_FILL: begin
                    if (accept) begin
                        if (wcnt == MAX_ENT) ovf_err <= 1'b1;
                        if (in_last) begin
                            cnt[wr_page] <= final_count(wcnt);
                            wr_page      <= wr_page + 1'b1;
                            wcnt         <= '0;
                            if (pages_next == PAGES_V) w_state <= W_WAIT;
                        end else if (wcnt != MAX_ENT) begin
                            wcnt <= wcnt + 5'd1;
                        end
                    end
                end
                default: w_state <= W_WAIT;
            endcase
        end
    end

    // Read side: issue page addresses against FIFO credit, then wait for the last entry to leave.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= R_IDLE;
            rd_page    <= '0;
            raddr      <= '0;
            ready_cnt  <= '0;
            pages_used <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            l1         <= 1'b0;
            l2         <= 1'b0;
        end else begin
            pages_used <= pages_next;
            ready_cnt  <= ready_next;
            v1         <= mem_enb;
            l1         <= mem_enb && last_addr;
            v2         <= v1;
            l2         <= l1;
            case (r_state)
                R_IDLE: begin
                    raddr <= '0;
                    if (ready_cnt != '0 || commit) r_state <= R_ISSUE;
                end
                R_ISSUE: begin
                    if (mem_enb) begin
                        if (last_addr) begin
                            raddr   <= '0;
                            r_state <= R_FLUSH;
                        end else begin
                            raddr <= raddr + 5'd1;
                        end
                    end
                end
                R_FLUSH: begin
                    if (free) begin
                        rd_page <= rd_page + 1'b1;
                        r_state <= R_IDLE;
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    page_out_fifo #(
        .WIDTH(RAM_WIDTH + 1)
    ) u_out_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (v2),
        .push_data ({mem_doutb, l2 && v2}),
        .pop       (out_ready),
        .out_valid (out_valid),
        .out_data  (fifo_out),
        .occupancy (occ)
    );

endmodule

// File: tb/tb_page_sequencer.sv
// Self-checking bench for page_sequencer with a behavioural 2-cycle dual-port RAM
// and an in-order scoreboard of expected output entries.
module tb_page_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_data;
    logic        in_last;
    logic        mem_wea;
    logic [1:0]  mem_pagea;
    logic [4:0]  mem_addra;
    logic [17:0] mem_dina;
    logic        mem_enb;
    logic [1:0]  mem_pageb;
    logic [4:0]  mem_addrb;
    logic        mem_regceb;
    logic        mem_rstb;
    logic [17:0] mem_doutb;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_data;
    logic        out_last;
    logic [4:0]  out_nent;
    logic        ovf_err;
    logic [2:0]  pages_used;

    typedef struct packed {
        logic [17:0] data;
        logic        last;
        logic [4:0]  nent;
    } exp_t;

    exp_t exp_q[$];
    int   n_vectors;
    int   n_miscompares;
    int   n_delivered;
    int   out_cnt;
    int   max_out;
    logic [1:0] exp_wpage;

    logic [17:0] ram [128];
    logic [17:0] rd1;

    page_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .mem_wea    (mem_wea),
        .mem_pagea  (mem_pagea),
        .mem_addra  (mem_addra),
        .mem_dina   (mem_dina),
        .mem_enb    (mem_enb),
        .mem_pageb  (mem_pageb),
        .mem_addrb  (mem_addrb),
        .mem_regceb (mem_regceb),
        .mem_rstb   (mem_rstb),
        .mem_doutb  (mem_doutb),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_nent   (out_nent),
        .ovf_err    (ovf_err),
        .pages_used (pages_used)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Buffer RAM model: write port A, read port B with a latch stage and an output register.
    always @(posedge clk) begin
        if (mem_wea) ram[{mem_pagea, mem_addra}] <= mem_dina;
        if (mem_enb) rd1 <= ram[{mem_pageb, mem_addrb}];
        if (mem_rstb) mem_doutb <= '0;
        else if (mem_regceb) mem_doutb <= rd1;
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called once per cycle at the falling edge: credit tracking and scoreboard comparison.
    task automatic monitor();
        exp_t e;
        if (!rst_n) return;
        if (mem_enb) out_cnt++;
        if (out_valid && out_ready) out_cnt--;
        if (out_cnt > max_out) max_out = out_cnt;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check_output("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = exp_q[0];
                check_output("out_data", 32'(out_data), 32'(e.data));
                check_output("out_last", 32'(out_last), 32'(e.last));
                check_output("out_nent", 32'(out_nent), 32'(e.nent));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_delivered++;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input bit do_checks);
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 18'h3ffff;
        in_last   = 1'b1;
        out_ready = 1'b1;
        exp_q.delete();
        out_cnt   = 0;
        exp_wpage = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        if (do_checks) begin
            check_output("rst_in_ready", 32'(in_ready), 32'd0);
            check_output("rst_mem_wea", 32'(mem_wea), 32'd0);
            check_output("rst_mem_enb", 32'(mem_enb), 32'd0);
            check_output("rst_out_valid", 32'(out_valid), 32'd0);
            check_output("rst_out_last", 32'(out_last), 32'd0);
            check_output("rst_ovf_err", 32'(ovf_err), 32'd0);
            check_output("rst_pages_used", 32'(pages_used), 32'd0);
            check_output("rst_out_nent", 32'(out_nent), 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        if (do_checks) check_output("in_ready_pre", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check_output("in_ready_up", 32'(in_ready), 32'd1);
    endtask

    // Offers one beat until accepted; checks the write port and records the expected output.
    task automatic drive_beat(input int data, input bit last, input int idx, input int nexp);
        bit acc;
        exp_t e;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = 18'(data);
        in_last  = last;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            monitor();
            if (in_ready) begin
                acc = 1'b1;
                check_output("mem_wea", 32'(mem_wea), 32'(idx < 31));
                if (idx < 31) begin
                    check_output("mem_addra", 32'(mem_addra), 32'(idx));
                    check_output("mem_pagea", 32'(mem_pagea), 32'(exp_wpage));
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!acc) begin
            check_output("in_timeout", 32'd0, 32'd1);
        end else begin
            if (idx < 31) begin
                e.data = 18'(data);
                e.last = (idx == nexp - 1);
                e.nent = 5'(nexp);
                exp_q.push_back(e);
            end
            if (last) exp_wpage = exp_wpage + 2'd1;
        end
    endtask

    task automatic apply_stimulus(input int n, input int base);
        int nexp;
        nexp = (n > 31) ? 31 : n;
        for (int i = 0; i < n; i++) drive_beat(base + i, i == n - 1, i, nexp);
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int t = 0; t < max_cycles && exp_q.size() != 0; t++) step();
        check_output("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int d0;
        n_vectors     = 0;
        n_miscompares = 0;
        n_delivered   = 0;
        max_out       = 0;
        rst_n         = 1'b0;
        in_valid      = 1'b0;
        in_data       = '0;
        in_last       = 1'b0;
        out_ready     = 1'b0;

        // Reset values, then a 3-entry event with a free-running sink
        apply_reset(1'b1);
        apply_stimulus(3, 1);
        check_output("commit_enb", 32'(mem_enb), 32'd1);
        check_output("commit_addrb", 32'(mem_addrb), 32'd0);
        check_output("commit_pageb", 32'(mem_pageb), 32'd0);
        check_output("commit_pages", 32'(pages_used), 32'd1);
        step();
        check_output("ov_c2", 32'(out_valid), 32'd0);
        step();
        check_output("ov_c3", 32'(out_valid), 32'd1);
        step();
        check_output("ov_c4", 32'(out_valid), 32'd1);
        step();
        check_output("ov_c5", 32'(out_valid), 32'd1);
        check_output("last_c5", 32'(out_last), 32'd1);
        wait_drain(50);
        check_output("pages_after_t1", 32'(pages_used), 32'd0);

        // Four 2-entry events into a stalled sink fill every page
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) apply_stimulus(2, 'h10 * (k + 2));
        check_output("full_pages", 32'(pages_used), 32'd4);
        check_output("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 18'h050;
        in_last  = 1'b0;
        repeat (8) step();
        check_output("stall_in_ready", 32'(in_ready), 32'd0);
        check_output("stall_wea", 32'(mem_wea), 32'd0);
        check_output("stall_max_out", 32'(max_out), 32'd2);
        out_ready = 1'b1;
        apply_stimulus(2, 'h50);
        wait_drain(100);
        check_output("pages_after_t2", 32'(pages_used), 32'd0);

        // Oversized event: only 31 entries kept, sticky overflow flag
        check_output("ovf_before", 32'(ovf_err), 32'd0);
        apply_stimulus(35, 'h1000);
        check_output("ovf_set", 32'(ovf_err), 32'd1);
        wait_drain(100);
        check_output("ovf_sticky", 32'(ovf_err), 32'd1);

        // Stalled then toggling sink during a 10-entry drain
        out_ready = 1'b0;
        max_out   = 0;
        apply_stimulus(10, 'h100);
        repeat (8) step();
        check_output("credit_stall", 32'(max_out), 32'd3);
        d0 = n_delivered;
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
            out_ready = ~out_ready;
            step();
        end
        check_output("toggle_drain", 32'(exp_q.size()), 32'd0);
        check_output("toggle_count", 32'(n_delivered - d0), 32'd10);
        check_output("credit_max", 32'(max_out), 32'd3);
        out_ready = 1'b1;
        repeat (3) step();

        // Commit of page 1 lands on the same edge as the out_last handshake of page 0
        apply_reset(1'b0);
        out_ready = 1'b0;
        apply_stimulus(2, 'h400);
        repeat (6) step();
        drive_beat('h410, 1'b0, 0, 3);
        out_ready = 1'b1;
        drive_beat('h411, 1'b0, 1, 3);
        check_output("same_pages_pre", 32'(pages_used), 32'd1);
        drive_beat('h412, 1'b1, 2, 3);
        check_output("same_pages", 32'(pages_used), 32'd1);
        check_output("same_ready_cnt", 32'(dut.ready_cnt), 32'd1);
        wait_drain(50);
        check_output("same_pages_end", 32'(pages_used), 32'd0);

        // Reset pulsed mid-drain
        out_ready = 1'b0;
        apply_stimulus(6, 'h200);
        repeat (6) step();
        check_output("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_out_valid", 32'(out_valid), 32'd0);
        check_output("async_pages", 32'(pages_used), 32'd0);
        check_output("async_enb", 32'(mem_enb), 32'd0);
        apply_reset(1'b0);
        out_ready = 1'b1;
        apply_stimulus(2, 'h300);
        wait_drain(50);
        repeat (5) step();
        check_output("post_rst_pages", 32'(pages_used), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
